// File: rtl/rename_map_table.sv
// Arch-to-phys rename table with per-branch checkpoints and a committed map for recovery.
// Lookups are combinational from the current map; writes land on the next edge; rename stalls on flush, mispredict or allocator full.
module rename_map_table #(
    parameter int ArchRegIDWidth = 4,
    parameter int PhyRegIDWidth  = 5,
    parameter int BridWidth      = 2,
    parameter int CommitWidth    = 1
) (
    input  logic                                         clk_i,
    input  logic                                         rst_i,
    input  logic                                         flush_i,
    input  logic                                         missprediction_i,
    input  logic [BridWidth-1:0]                         missprediction_brid_i,
    input  logic                                         rename_valid_i,
    input  logic                                         rename_has_dest_i,
    input  logic [ArchRegIDWidth-1:0]                    rename_dest_i,
    input  logic [ArchRegIDWidth-1:0]                    rename_src1_i,
    input  logic [ArchRegIDWidth-1:0]                    rename_src2_i,
    input  logic                                         rename_checkpoint_i,
    input  logic [BridWidth-1:0]                         rename_brid_i,
    output logic                                         rename_ready_o,
    output logic [PhyRegIDWidth-1:0]                     rename_src1_tag_o,
    output logic [PhyRegIDWidth-1:0]                     rename_src2_tag_o,
    output logic [PhyRegIDWidth-1:0]                     rename_dest_tag_o,
    output logic [PhyRegIDWidth-1:0]                     rename_old_tag_o,
    input  logic [PhyRegIDWidth-1:0]                     alloc_tag_i,
    input  logic                                         alloc_full_i,
    output logic                                         alloc_o,
    output logic                                         alloc_new_checkpoint_o,
    output logic [BridWidth-1:0]                         alloc_brid_o,
    input  logic [CommitWidth-1:0]                       commit_i,
    input  logic [CommitWidth-1:0][ArchRegIDWidth-1:0]   commit_arch_i,
    input  logic [CommitWidth-1:0][PhyRegIDWidth-1:0]    commit_tag_i
);

    localparam int NumArchRegs    = 2 ** ArchRegIDWidth;
    localparam int NumCheckpoints = 2 ** BridWidth;

    typedef logic [NumArchRegs-1:0][PhyRegIDWidth-1:0] map_t;

    map_t                          spec_map_q, spec_map_d;
    map_t                          commit_map_q, commit_map_d;
    map_t [NumCheckpoints-1:0]     ckpt_q, ckpt_d;
    map_t                          spec_wr;

    // Reset state mirrors the allocator: tags 0..NumArchRegs-1 are already in use.
    function automatic map_t identity_map();
        map_t m;
        for (int a = 0; a < NumArchRegs; a++) begin
            m[a] = PhyRegIDWidth'(a);
        end
        return m;
    endfunction

    assign rename_ready_o = rename_valid_i & ~flush_i & ~missprediction_i &
                            ~(rename_has_dest_i & alloc_full_i);
    assign alloc_o                = rename_ready_o & rename_has_dest_i;
    assign alloc_new_checkpoint_o = rename_ready_o & rename_checkpoint_i;
    assign alloc_brid_o           = rename_brid_i;

    assign rename_src1_tag_o = spec_map_q[rename_src1_i];
    assign rename_src2_tag_o = spec_map_q[rename_src2_i];
    assign rename_old_tag_o  = spec_map_q[rename_dest_i];
    assign rename_dest_tag_o = alloc_tag_i;

    always_comb begin
        spec_wr = spec_map_q;
        if (alloc_o) begin
            spec_wr[rename_dest_i] = alloc_tag_i;
        end

        // Ascending slot order so the highest slot wins on a shared arch reg.
        commit_map_d = commit_map_q;
        for (int s = 0; s < CommitWidth; s++) begin
            if (commit_i[s]) begin
                commit_map_d[commit_arch_i[s]] = commit_tag_i[s];
            end
        end

        ckpt_d = ckpt_q;
        if (alloc_new_checkpoint_o) begin
            ckpt_d[rename_brid_i] = spec_wr;
        end

        if (flush_i) begin
            spec_map_d = commit_map_d;
        end else if (missprediction_i) begin
            spec_map_d = ckpt_q[missprediction_brid_i];
        end else begin
            spec_map_d = spec_wr;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            spec_map_q   <= identity_map();
            commit_map_q <= identity_map();
            for (int b = 0; b < NumCheckpoints; b++) begin
                ckpt_q[b] <= identity_map();
            end
        end else begin
            spec_map_q   <= spec_map_d;
            commit_map_q <= commit_map_d;
            ckpt_q       <= ckpt_d;
        end
    end

endmodule

// File: tb/tb_rename_map_table.sv
// Bench for rename_map_table: directed vector table, then random traffic against an array model.
module tb_rename_map_table;

    localparam int AW = 4;
    localparam int PW = 5;
    localparam int BW = 2;
    localparam int CW = 2;

    logic                   clk_i = 1'b0;
    logic                   rst_i;
    logic                   flush_i;
    logic                   missprediction_i;
    logic [BW-1:0]          missprediction_brid_i;
    logic                   rename_valid_i;
    logic                   rename_has_dest_i;
    logic [AW-1:0]          rename_dest_i;
    logic [AW-1:0]          rename_src1_i;
    logic [AW-1:0]          rename_src2_i;
    logic                   rename_checkpoint_i;
    logic [BW-1:0]          rename_brid_i;
    logic                   rename_ready_o;
    logic [PW-1:0]          rename_src1_tag_o;
    logic [PW-1:0]          rename_src2_tag_o;
    logic [PW-1:0]          rename_dest_tag_o;
    logic [PW-1:0]          rename_old_tag_o;
    logic [PW-1:0]          alloc_tag_i;
    logic                   alloc_full_i;
    logic                   alloc_o;
    logic                   alloc_new_checkpoint_o;
    logic [BW-1:0]          alloc_brid_o;
    logic [CW-1:0]          commit_i;
    logic [CW-1:0][AW-1:0]  commit_arch_i;
    logic [CW-1:0][PW-1:0]  commit_tag_i;

    rename_map_table #(
        .ArchRegIDWidth(AW), .PhyRegIDWidth(PW), .BridWidth(BW), .CommitWidth(CW)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .missprediction_i(missprediction_i), .missprediction_brid_i(missprediction_brid_i),
        .rename_valid_i(rename_valid_i), .rename_has_dest_i(rename_has_dest_i),
        .rename_dest_i(rename_dest_i), .rename_src1_i(rename_src1_i), .rename_src2_i(rename_src2_i),
        .rename_checkpoint_i(rename_checkpoint_i), .rename_brid_i(rename_brid_i),
        .rename_ready_o(rename_ready_o), .rename_src1_tag_o(rename_src1_tag_o),
        .rename_src2_tag_o(rename_src2_tag_o), .rename_dest_tag_o(rename_dest_tag_o),
        .rename_old_tag_o(rename_old_tag_o), .alloc_tag_i(alloc_tag_i), .alloc_full_i(alloc_full_i),
        .alloc_o(alloc_o), .alloc_new_checkpoint_o(alloc_new_checkpoint_o), .alloc_brid_o(alloc_brid_o),
        .commit_i(commit_i), .commit_arch_i(commit_arch_i), .commit_tag_i(commit_tag_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit       rst, flush, mp;
        bit [1:0] mp_brid;
        bit       valid, hd;
        bit [3:0] dest, s1, s2;
        bit       ck;
        bit [1:0] brid;
        bit [4:0] tag;
        bit       full;
        bit [1:0] cv;
        bit [3:0] ca0, ca1;
        bit [4:0] ct0, ct1;
        bit       e_ready, e_alloc, e_ck;
        int       e_s1, e_s2, e_old;
    } vec_t;

    vec_t tbl[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model state: plain integer arrays.
    int m_spec[16];
    int m_com[16];
    int m_ck[4][16];

    function automatic vec_t rn(bit valid, bit hd, int dest, int s1, int s2, bit ck, int brid,
                                int tag, bit full, bit er, bit ea, bit ec, int es1, int es2, int eold);
        vec_t v;
        v.rst = 0; v.flush = 0; v.mp = 0; v.mp_brid = 0;
        v.valid = valid; v.hd = hd; v.dest = 4'(dest); v.s1 = 4'(s1); v.s2 = 4'(s2);
        v.ck = ck; v.brid = 2'(brid); v.tag = 5'(tag); v.full = full;
        v.cv = 0; v.ca0 = 0; v.ca1 = 0; v.ct0 = 0; v.ct1 = 0;
        v.e_ready = er; v.e_alloc = ea; v.e_ck = ec; v.e_s1 = es1; v.e_s2 = es2; v.e_old = eold;
        return v;
    endfunction

    task automatic chk(string name, int act, int exp);
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at vector %0d: got %0d, expected %0d", name, vectors, act, exp);
        end
    endtask

    task automatic drive(vec_t v);
        rst_i = v.rst; flush_i = v.flush; missprediction_i = v.mp; missprediction_brid_i = v.mp_brid;
        rename_valid_i = v.valid; rename_has_dest_i = v.hd; rename_dest_i = v.dest;
        rename_src1_i = v.s1; rename_src2_i = v.s2; rename_checkpoint_i = v.ck; rename_brid_i = v.brid;
        alloc_tag_i = v.tag; alloc_full_i = v.full; commit_i = v.cv;
        commit_arch_i[0] = v.ca0; commit_arch_i[1] = v.ca1;
        commit_tag_i[0] = v.ct0; commit_tag_i[1] = v.ct1;
    endtask

    task automatic check(vec_t v);
        vectors++;
        chk("ready", int'(rename_ready_o), int'(v.e_ready));
        chk("alloc", int'(alloc_o), int'(v.e_alloc));
        chk("new_ckpt", int'(alloc_new_checkpoint_o), int'(v.e_ck));
        chk("src1_tag", int'(rename_src1_tag_o), v.e_s1);
        chk("src2_tag", int'(rename_src2_tag_o), v.e_s2);
        chk("old_tag", int'(rename_old_tag_o), v.e_old);
        chk("dest_tag", int'(rename_dest_tag_o), int'(v.tag));
        chk("alloc_brid", int'(alloc_brid_o), int'(v.brid));
    endtask

    // Model: derive expectations for v from the architectural rules.
    function automatic vec_t predict(vec_t v);
        vec_t e = v;
        e.e_ready = v.valid && !v.flush && !v.mp && !(v.hd && v.full);
        e.e_alloc = e.e_ready && v.hd;
        e.e_ck    = e.e_ready && v.ck;
        e.e_s1    = m_spec[v.s1];
        e.e_s2    = m_spec[v.s2];
        e.e_old   = m_spec[v.dest];
        return e;
    endfunction

    task automatic model_step(vec_t e);
        int nspec[16];
        if (e.rst) begin
            for (int a = 0; a < 16; a++) begin
                m_spec[a] = a; m_com[a] = a;
                for (int b = 0; b < 4; b++) m_ck[b][a] = a;
            end
            return;
        end
        nspec = m_spec;
        if (e.e_alloc) nspec[e.dest] = e.tag;
        if (e.e_ck) m_ck[e.brid] = nspec;
        if (e.cv[0]) m_com[e.ca0] = e.ct0;
        if (e.cv[1]) m_com[e.ca1] = e.ct1;
        if (e.flush) m_spec = m_com;
        else if (e.mp) m_spec = m_ck[e.mp_brid];
        else m_spec = nspec;
    endtask

    initial begin
        vec_t v;

        // Directed table; expected values hand-derived from reset state onward.
        tbl.push_back(rn(0,0,0, 5,15,0,0,0,0,  0,0,0, 5,15,0));
        tbl.push_back(rn(1,1,3, 3,4,0,0,16,0,  1,1,0, 3,4,3));
        tbl.push_back(rn(1,0,3, 3,0,0,0,0,1,   1,0,0, 16,0,16));
        tbl.push_back(rn(1,1,3, 3,0,0,0,25,1,  0,0,0, 16,0,16));
        tbl.push_back(rn(0,0,0, 3,4,0,0,0,0,   0,0,0, 16,4,0));
        tbl.push_back(rn(1,1,1, 1,2,1,2,17,0,  1,1,1, 1,2,1));
        tbl.push_back(rn(1,1,1, 1,3,0,0,18,0,  1,1,0, 17,16,17));
        v = rn(1,1,1, 1,3,0,0,19,0, 0,0,0, 18,16,18); v.mp = 1; v.mp_brid = 2; tbl.push_back(v);
        tbl.push_back(rn(0,0,0, 1,3,0,0,0,0,   0,0,0, 17,16,0));
        tbl.push_back(rn(1,1,2, 2,1,0,0,21,0,  1,1,0, 2,17,2));
        v = rn(0,0,0, 2,1,0,0,0,0, 0,0,0, 21,17,0); v.flush = 1; v.cv = 2'b01; v.ca0 = 2; v.ct0 = 20;
        tbl.push_back(v);
        tbl.push_back(rn(0,0,0, 2,1,0,0,0,0,   0,0,0, 20,1,0));
        v = rn(0,0,0, 5,2,0,0,0,0, 0,0,0, 5,20,0); v.flush = 1; v.cv = 2'b11;
        v.ca0 = 5; v.ca1 = 5; v.ct0 = 22; v.ct1 = 23; tbl.push_back(v);
        tbl.push_back(rn(0,0,0, 5,2,0,0,0,0,   0,0,0, 23,20,0));
        v = rn(0,0,0, 1,3,0,0,0,0, 0,0,0, 1,3,0); v.flush = 1; v.mp = 1; v.mp_brid = 2; tbl.push_back(v);
        tbl.push_back(rn(0,0,0, 1,3,0,0,0,0,   0,0,0, 1,3,0));
        tbl.push_back(rn(1,1,7, 7,5,0,0,30,0,  1,1,0, 7,23,7));
        v = rn(1,1,8, 7,2,0,0,31,0, 1,1,0, 30,20,8); v.rst = 1; tbl.push_back(v);
        tbl.push_back(rn(0,0,0, 7,5,0,0,0,0,   0,0,0, 7,5,0));
        v = rn(0,0,0, 8,2,0,0,0,0, 0,0,0, 8,2,0); v.flush = 1; tbl.push_back(v);
        tbl.push_back(rn(0,0,0, 2,5,0,0,0,0,   0,0,0, 2,5,0));
        tbl.push_back(rn(1,0,0, 4,0,1,1,0,1,   1,0,1, 4,0,0));
        tbl.push_back(rn(1,1,4, 4,0,0,0,12,0,  1,1,0, 4,0,4));
        v = rn(0,0,0, 4,0,0,0,0,0, 0,0,0, 12,0,0); v.mp = 1; v.mp_brid = 1; tbl.push_back(v);
        tbl.push_back(rn(0,0,0, 4,0,0,0,0,0,   0,0,0, 4,0,0));

        // Reset prelude.
        v = rn(0,0,0, 0,0,0,0,0,0, 0,0,0, 0,0,0); v.rst = 1;
        @(negedge clk_i); drive(v);
        @(posedge clk_i); @(negedge clk_i);
        @(posedge clk_i);

        foreach (tbl[i]) begin
            @(negedge clk_i);
            drive(tbl[i]);
            #1 check(tbl[i]);
            @(posedge clk_i);
        end

        // Random phase: one unchecked reset cycle to align the model.
        @(negedge clk_i); drive(v);
        @(posedge clk_i);
        model_step(v);
        for (int n = 0; n < 2000; n++) begin
            vec_t r, e;
            r = rn(0,0,0, 0,0,0,0,0,0, 0,0,0, 0,0,0);
            r.rst     = ($urandom_range(0, 63) == 0);
            r.flush   = ($urandom_range(0, 19) == 0);
            r.mp      = ($urandom_range(0, 11) == 0);
            r.mp_brid = 2'($urandom_range(0, 3));
            r.valid   = ($urandom_range(0, 3) != 0);
            r.hd      = ($urandom_range(0, 3) != 0);
            r.dest    = 4'($urandom_range(0, 15));
            r.s1      = 4'($urandom_range(0, 15));
            r.s2      = 4'($urandom_range(0, 15));
            r.ck      = ($urandom_range(0, 3) == 0);
            r.brid    = 2'($urandom_range(0, 3));
            r.tag     = 5'($urandom_range(0, 31));
            r.full    = ($urandom_range(0, 4) == 0);
            r.cv      = 2'($urandom_range(0, 3));
            r.ca0     = 4'($urandom_range(0, 15));
            r.ca1     = ($urandom_range(0, 3) == 0) ? r.ca0 : 4'($urandom_range(0, 15));
            r.ct0     = 5'($urandom_range(0, 31));
            r.ct1     = 5'($urandom_range(0, 31));
            e = predict(r);
            @(negedge clk_i);
            drive(e);
            #1 check(e);
            @(posedge clk_i);
            model_step(e);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
